// File: rtl/ap_ctrl_driver_if.sv
// rtl/ap_ctrl_driver_if.sv - ap_start/ap_ready/ap_done/ap_continue block-level handshake bundle
interface ap_ctrl_driver_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (output ap_start, output ap_continue, input ap_ready, input ap_done);
    modport slave  (input ap_start, input ap_continue, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_driver.sv
// rtl/ap_ctrl_driver.sv - ap_ctrl handshake initiator with outstanding limit, continue stall and latency measurement
module ap_ctrl_driver #(
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 4,
    parameter int STALL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [CNT_W-1:0]   cfg_num_trans,
    input  logic [STALL_W-1:0] cfg_cont_stall,
    ap_ctrl_driver_if.master   ap,
    output logic               busy,
    output logic               run_done,
    output logic [CNT_W-1:0]   started_cnt,
    output logic [CNT_W-1:0]   done_cnt,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   max_latency,
    output logic [CNT_W-1:0]   total_cycles,
    output logic               err_protocol
);
    localparam int OW    = $clog2(MAX_OUT) + 1;
    localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int DEPTH = 1 << PW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_reg;
    logic [STALL_W-1:0] stall_reg;
    logic [STALL_W-1:0] stall_cnt;
    logic [OW-1:0]      outstanding;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   fifo [0:DEPTH-1];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic               start_acc;
    logic               done_acc;
    logic               bypass;
    logic               proto_err;
    logic               normal_done;
    logic               done_ok;
    logic               push;
    logic [CNT_W-1:0]   latency;

    // Handshake outputs come only from registers, so no input-to-output path exists.
    assign ap.ap_start    = (state == RUN) && (started_cnt < num_reg) && (outstanding < OW'(MAX_OUT));
    assign ap.ap_continue = (stall_cnt == '0);

    assign start_acc   = ap.ap_start & ap.ap_ready;
    assign done_acc    = ap.ap_done & ap.ap_continue;
    assign bypass      = done_acc & (outstanding == '0) & start_acc;
    assign proto_err   = done_acc & (outstanding == '0) & ~start_acc;
    assign normal_done = done_acc & (outstanding != '0);
    assign done_ok     = bypass | normal_done;
    assign push        = start_acc & ~bypass;
    assign latency     = bypass ? '0 : (cycle_cnt - fifo[rd_ptr]);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wr_ptr] <= cycle_cnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            num_reg      <= '0;
            stall_reg    <= '0;
            stall_cnt    <= '0;
            outstanding  <= '0;
            cycle_cnt    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            started_cnt  <= '0;
            done_cnt     <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            total_cycles <= '0;
            err_protocol <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            run_done  <= 1'b0;

            if (done_acc) begin
                stall_cnt <= stall_reg;
            end else if (stall_cnt != '0) begin
                stall_cnt <= stall_cnt - 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (normal_done) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (start_acc && !done_ok) begin
                outstanding <= outstanding + 1'b1;
            end else if (done_ok && !start_acc) begin
                outstanding <= outstanding - 1'b1;
            end

            if (start_acc) begin
                started_cnt <= started_cnt + 1'b1;
            end
            if (proto_err) begin
                err_protocol <= 1'b1;
            end
            if (done_ok) begin
                done_cnt     <= done_cnt + 1'b1;
                last_latency <= latency;
                if (latency > max_latency) begin
                    max_latency <= latency;
                end
            end

            if ((state == RUN || state == DRAIN) && total_cycles != '1) begin
                total_cycles <= total_cycles + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        num_reg      <= cfg_num_trans;
                        stall_reg    <= cfg_cont_stall;
                        started_cnt  <= '0;
                        done_cnt     <= '0;
                        last_latency <= '0;
                        max_latency  <= '0;
                        total_cycles <= '0;
                        err_protocol <= 1'b0;
                        if (cfg_num_trans == '0) begin
                            state    <= FIN;
                            run_done <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (started_cnt == num_reg) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        run_done <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ap_ctrl_driver.md
Name: ap_ctrl_driver

Overview:
- Synthesizable initiator for the ap_start/ap_ready/ap_done/ap_continue block-level handshake, i.e. the driving end of the protocol that the dataflow module monitors observe.
- Issues a programmed number of transactions to a kernel, keeps up to MAX_OUT in flight, and applies configurable ap_continue back-pressure.
- Measures per-transaction latency and total run time for on-board characterisation of HLS accelerators.

Parameters:
CNT_W, 32, width of all counters, timestamps and latency outputs
MAX_OUT, 4, maximum outstanding transactions (started, not yet done); power of two, >=1
STALL_W, 8, width of the ap_continue stall configuration

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high
cfg_start  in  1  pulse; begins a run, honoured only in IDLE
cfg_num_trans  in  CNT_W  transactions in the run, sampled on cfg_start
cfg_cont_stall  in  STALL_W  cycles ap_continue is held low after each accepted done, sampled on cfg_start
ap_start  out  1  to kernel
ap_ready  in  1  from kernel
ap_done  in  1  from kernel
ap_continue  out  1  to kernel
busy  out  1  high in RUN and DRAIN
run_done  out  1  one-cycle pulse at end of run
started_cnt  out  CNT_W  accepted starts
done_cnt  out  CNT_W  accepted dones
last_latency  out  CNT_W  latency of the most recent done
max_latency  out  CNT_W  maximum latency in the run, saturating
total_cycles  out  CNT_W  cycles from leaving IDLE to entering FIN, saturating
err_protocol  out  1  sticky, cleared on cfg_start

Behaviour:
- Reset (async): state=IDLE; all counters, latency outputs, err_protocol, busy, run_done and ap_start = 0; stall counter = 0, so ap_continue = 1.
- Events:
  - start accept = ap_start & ap_ready in the same cycle.
  - done accept = ap_done & ap_continue in the same cycle.
- ap_start = (state==RUN) & (started_cnt < num_reg) & (outstanding < MAX_OUT). It depends only on registers, so there is no combinational path from any input.
- ap_continue = (stall_cnt == 0).
  - stall_cnt loads cfg_cont_stall on every done accept and decrements to 0.
  - With stall 0, ap_continue is constantly 1.
- outstanding: +1 on start accept, -1 on done accept, unchanged when both occur in the same cycle.
- Timestamp FIFO, depth MAX_OUT:
  - A free-running cycle_cnt (wraps) is pushed on start accept and popped on done accept.
  - latency = cycle_cnt - head, modulo 2^CNT_W.
  - Bypass: done accept with outstanding==0 in the same cycle as a start accept gives latency 0, is counted normally, and is not an error.
- Protocol error: done accept with outstanding==0 and no simultaneous start accept.
  - err_protocol is set; done_cnt and latency outputs are unchanged; no FIFO pop.
- Per done accept: last_latency <= latency; max_latency <= max(max_latency, latency); done_cnt++.
- FSM:
  - IDLE: on cfg_start, clear counters, latency outputs and err_protocol, and latch the config. If num==0 go to FIN, else go to RUN. cfg_start outside IDLE is ignored.
  - RUN: issue starts. Go to DRAIN in the cycle after started_cnt reaches num_reg.
  - DRAIN: ap_start=0. Go to FIN when outstanding==0. Dones are still accepted.
  - FIN: run_done=1 for one cycle, then IDLE. Counters hold their values until the next cfg_start.
- total_cycles increments every cycle in RUN and DRAIN, saturating at all-ones.
- Dones arriving in IDLE or FIN with outstanding==0 are protocol errors; done_cnt is unaffected.
- Reset mid-run: everything returns to reset values immediately; in-flight kernel transactions are abandoned.

Test Plan:
1. num=1, stall=0, kernel asserts ap_ready with start and ap_done 5 cycles later -> started=1, done=1, last/max_latency=5, one run_done pulse, err=0.
2. num=8, MAX_OUT=4, kernel ap_ready immediate, ap_done 10 cycles after each start -> ap_start drops after 4 accepts, outstanding never exceeds 4, done=8, max_latency=10.
3. num=3, stall=2, kernel holds ap_done high continuously -> ap_continue low exactly 2 cycles after each accept, done_cnt=3, run ends in FIN.
4. num=2, combinational kernel (ap_ready & ap_done together with start) -> bypass path, latency 0, err_protocol=0.
5. Spurious ap_done in IDLE, then cfg_start with num=0 -> err set, then cleared by cfg_start; run_done pulses one cycle after cfg_start; counters 0.
6. Assert reset while outstanding=3 in RUN -> immediate IDLE, ap_start=0, ap_continue=1, all counters 0.
